// File: rtl/riscv_obi_arb_pkg.sv
// Shared types for the two-requester OBI memory arbiter.
// The address-phase struct is sized by the package widths below; the arbiter's
// ADDR_WIDTH / DATA_WIDTH parameters default to these and must be kept equal.
package riscv_obi_arb_pkg;

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiBeWidth   = 4;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } obi_req_id_e;

    typedef struct packed {
        logic [ObiAddrWidth-1:0] addr;
        logic                    we;
        logic [ObiBeWidth-1:0]   be;
        logic [ObiDataWidth-1:0] wdata;
    } obi_addr_phase_t;

endpackage

// File: rtl/riscv_obi_arb_fifo.sv
// In-order FIFO of requester ids: one entry per granted, not yet answered
// transaction. Pointers wrap modulo Depth, so Depth need not be a power of 2.
module riscv_obi_arb_fifo
    import riscv_obi_arb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  obi_req_id_e id_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        empty_o,
    output obi_req_id_e head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    obi_req_id_e     mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            push_ok, pop_ok;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Storage, pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= REQ_INSTR;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= id_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (!push_ok && pop_ok) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/riscv_obi_mem_arbiter.sv
// Shares one OBI memory port between the instruction (0) and data (1) requesters.
// Round-robin selection, address phase held (locked) until granted, and in-order
// routing of responses back to their originator. err_o is a sticky protocol flag.
// Optional build macro OBI_ARB_STARVE_BOOST_EN adds per-requester wait counters
// that give a starved requester absolute priority once they reach STARVE_LIMIT.
module riscv_obi_mem_arbiter
    import riscv_obi_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_WIDTH      = ObiAddrWidth,
    parameter int unsigned DATA_WIDTH      = ObiDataWidth,
    parameter int unsigned STARVE_LIMIT    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [1:0]                 req_i,
    output logic [1:0]                 gnt_o,
    input  logic [1:0][ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]                 we_i,
    input  logic [1:0][3:0]            be_i,
    input  logic [1:0][DATA_WIDTH-1:0] wdata_i,
    output logic [1:0]                 rvalid_o,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic                       mem_req_o,
    input  logic                       mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]      mem_addr_o,
    output logic                       mem_we_o,
    output logic [3:0]                 mem_be_o,
    output logic [DATA_WIDTH-1:0]      mem_wdata_o,
    input  logic                       mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]      mem_rdata_i,
    output logic                       err_o
);

    obi_req_id_e     sel, rr_ptr_q, locked_id_q, head;
    logic            lock_q, err_q;
    logic            fifo_full, fifo_empty, push, pop;
    obi_addr_phase_t phase;

`ifdef OBI_ARB_STARVE_BOOST_EN
    localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);

    logic [1:0][WaitW-1:0] wait_cnt_q;
    logic [1:0]            starved;

    // A requester is starved while it is still asking and its wait count hit the limit.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            starved[i] = req_i[i] && (wait_cnt_q[i] >= WaitW'(STARVE_LIMIT));
        end
    end

    // Wait counters: count ungranted request cycles, saturate, clear on grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (gnt_o[i]) begin
                    wait_cnt_q[i] <= '0;
                end else if (req_i[i] && (wait_cnt_q[i] < WaitW'(STARVE_LIMIT))) begin
                    wait_cnt_q[i] <= wait_cnt_q[i] + WaitW'(1);
                end
            end
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
`endif

    // Selection: a held lock wins, then (optionally) starvation, then round-robin.
    always_comb begin
        sel = rr_ptr_q;
        if (lock_q) begin
            sel = locked_id_q;
`ifdef OBI_ARB_STARVE_BOOST_EN
        end else if (starved[REQ_DATA]) begin
            sel = REQ_DATA;
        end else if (starved[REQ_INSTR]) begin
            sel = REQ_INSTR;
`endif
        end else if (req_i[rr_ptr_q]) begin
            sel = rr_ptr_q;
        end else if (req_i[~rr_ptr_q]) begin
            sel = obi_req_id_e'(~rr_ptr_q);
        end
    end

    // A full route FIFO blocks new requests even if it pops this cycle.
    assign mem_req_o = req_i[sel] & ~fifo_full;
    assign push      = mem_req_o & mem_gnt_i;
    assign pop       = mem_rvalid_i & ~fifo_empty;

    assign phase.addr  = addr_i[sel];
    assign phase.we    = we_i[sel];
    assign phase.be    = be_i[sel];
    assign phase.wdata = wdata_i[sel];

    assign mem_addr_o  = phase.addr;
    assign mem_we_o    = phase.we;
    assign mem_be_o    = phase.be;
    assign mem_wdata_o = phase.wdata;
    assign rdata_o     = mem_rdata_i;
    assign err_o       = err_q;

    // Per-requester grant and response strobes.
    always_comb begin
        gnt_o         = '0;
        gnt_o[sel]    = push;
        rvalid_o      = '0;
        rvalid_o[head] = pop;
    end

    // Lock, round-robin pointer and sticky error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q      <= 1'b0;
            locked_id_q <= REQ_INSTR;
            rr_ptr_q    <= REQ_INSTR;
            err_q       <= 1'b0;
        end else begin
            if (lock_q && !req_i[locked_id_q]) begin
                // Requester withdrew an ungranted address phase.
                lock_q <= 1'b0;
                err_q  <= 1'b1;
            end else if (mem_req_o && !mem_gnt_i) begin
                lock_q      <= 1'b1;
                locked_id_q <= sel;
            end else if (push) begin
                lock_q <= 1'b0;
            end
            if (push) begin
                rr_ptr_q <= obi_req_id_e'(~sel);
            end
            if (mem_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    riscv_obi_arb_fifo #(
        .Depth (MAX_OUTSTANDING)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .id_i    (sel),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

endmodule

// File: tb/tb_riscv_obi_mem_arbiter.sv
// Directed bench for riscv_obi_mem_arbiter (default build, MAX_OUTSTANDING=2).
// Stimulus pushes each expected response into a scoreboard queue; a separate
// negedge monitor pops and checks routing and data whenever rvalid_o fires.
module tb_riscv_obi_mem_arbiter;

    logic             clk_i, rst_ni;
    logic [1:0]       req_i, gnt_o, we_i, rvalid_o;
    logic [1:0][31:0] addr_i, wdata_i;
    logic [1:0][3:0]  be_i;
    logic [31:0]      rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic             mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, err_o;
    logic [3:0]       mem_be_o;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   vec_n = 0;

    riscv_obi_mem_arbiter #(
        .MAX_OUTSTANDING (2),
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .STARVE_LIMIT    (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_rsp(input logic id, input logic [31:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic [31:0] rd);
        req_i        = req;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
    endtask

    // One cycle from posedge+1: drive, optionally expect a routed response, check at negedge.
    task automatic cyc(input string name, input logic [1:0] req, input logic gnt,
                       input logic rv, input logic rsp_ok, input logic rsp_id,
                       input logic [1:0] exp_gnt, input logic exp_mreq,
                       input logic [31:0] exp_addr, input logic exp_err);
        logic [31:0] rd;
        rd = 32'hB000_0000 + 32'(vec_n);
        vec_n++;
        drive(req, gnt, rv, rd);
        if (rv && rsp_ok) expect_rsp(rsp_id, rd);
        @(negedge clk_i);
        check({name, "_gnt"}, 32'(gnt_o), 32'(exp_gnt));
        check({name, "_mreq"}, 32'(mem_req_o), 32'(exp_mreq));
        if (exp_mreq) check({name, "_addr"}, mem_addr_o, exp_addr);
        if (rv && !rsp_ok) check({name, "_norsp"}, 32'(rvalid_o), 32'h0);
        check({name, "_err"}, 32'(err_o), 32'(exp_err));
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        rst_ni = 1'b0;
        #2;
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_rvalid", 32'(rvalid_o), 32'h0);
        check("rst_mreq", 32'(mem_req_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni && (rvalid_o != 2'b00)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: rvalid_o=%b, expected no response", rvalid_o);
            end else begin
                e = sb.pop_front();
                check("rsp_route", 32'(rvalid_o), e.id ? 32'h2 : 32'h1);
                check("rsp_data", rdata_o, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk_i   = 1'b0;
        rst_ni  = 1'b0;
        we_i    = 2'b10;
        be_i[0] = 4'hF;
        be_i[1] = 4'h3;
        wdata_i[0] = 32'h1111_1111;
        wdata_i[1] = 32'h2222_2222;
        addr_i[0]  = 32'h0;
        addr_i[1]  = 32'h0;
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        @(posedge clk_i);
        #1;
        do_reset();

        // Single requester, back-to-back grants, response one cycle later.
        for (int i = 0; i < 4; i++) begin
            addr_i[0] = 32'h100 + 32'(4 * i);
            drive((i < 3) ? 2'b01 : 2'b00, 1'b1, i > 0, 32'hD000_0000 + 32'(i));
            if (i > 0) expect_rsp(1'b0, 32'hD000_0000 + 32'(i));
            @(negedge clk_i);
            if (i < 3) begin
                check("single_gnt", 32'(gnt_o), 32'h1);
                check("single_addr", mem_addr_o, 32'h100 + 32'(4 * i));
            end
            check("single_err", 32'(err_o), 32'h0);
            @(posedge clk_i);
            #1;
        end

        // Contention: grants alternate 0,1,0,1 and the whole phase follows the winner.
        do_reset();
        addr_i[0] = 32'h200;
        addr_i[1] = 32'h300;
        for (int i = 0; i < 5; i++) begin
            drive((i < 4) ? 2'b11 : 2'b00, 1'b1, i > 0, 32'hC000_0000 + 32'(i));
            if (i > 0) expect_rsp(((i - 1) % 2) == 1, 32'hC000_0000 + 32'(i));
            @(negedge clk_i);
            if (i < 4) begin
                if ((i % 2) == 0) begin
                    check("cont_gnt", 32'(gnt_o), 32'h1);
                    check("cont_addr", mem_addr_o, 32'h200);
                    check("cont_we", 32'(mem_we_o), 32'h0);
                    check("cont_be", 32'(mem_be_o), 32'hF);
                    check("cont_wdata", mem_wdata_o, 32'h1111_1111);
                end else begin
                    check("cont_gnt", 32'(gnt_o), 32'h2);
                    check("cont_addr", mem_addr_o, 32'h300);
                    check("cont_we", 32'(mem_we_o), 32'h1);
                    check("cont_be", 32'(mem_be_o), 32'h3);
                    check("cont_wdata", mem_wdata_o, 32'h2222_2222);
                end
            end
            @(posedge clk_i);
            #1;
        end

        // Stall lock: rr_ptr points at 1, but the stalled requester 0 keeps the port.
        do_reset();
        addr_i[0] = 32'h400;
        addr_i[1] = 32'h500;
        cyc("stall0", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 32'h400, 1'b0);
        cyc("stall1", 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h400, 1'b0);
        cyc("stall2", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h400, 1'b0);
        cyc("stall3", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h400, 1'b0);
        cyc("stall4", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 32'h400, 1'b0);
        cyc("stall5", 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 32'h500, 1'b0);
        cyc("stall6", 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0);

        // FIFO full: two grants, requests blocked until a pop has taken effect.
        do_reset();
        addr_i[0] = 32'h600;
        addr_i[1] = 32'h700;
        cyc("full0", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 32'h600, 1'b0);
        cyc("full1", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 32'h700, 1'b0);
        cyc("full2", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
        cyc("full3", 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
        cyc("full4", 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 32'h600, 1'b0);
        cyc("full5", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);

        // Spurious response: dropped, sticky error until reset.
        do_reset();
        cyc("spur0", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
        cyc("spur1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1);
        cyc("spur2", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1);

        // Locked requester withdraws: error, lock released, requester 1 served next.
        do_reset();
        addr_i[0] = 32'h800;
        addr_i[1] = 32'h900;
        cyc("drop0", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h800, 1'b0);
        cyc("drop1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
        cyc("drop2", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 32'h900, 1'b1);
        cyc("drop3", 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 1'b1);

        // Reset with a transaction in flight: its late response is treated as spurious.
        do_reset();
        cyc("mid0", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 32'h800, 1'b0);
        do_reset();
        cyc("mid1", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
        cyc("mid2", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1);

        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
